// File: rtl/btn_debounce.sv
// btn_debounce: per-channel two-flop synchronizer, bounce filter and
// single-cycle press/release pulse generator for board push-buttons and
// slide switches.
// Optional feature: define BTN_DEBOUNCE_REPEAT_EN to add a per-channel
// auto-repeat timer that re-pulses btn_press while a button stays held.
module btn_debounce #(
  parameter int N       = 4,
  parameter int DEB_MAX = 65535,
  parameter int REP_DLY = 8000000,
  parameter int REP_PER = 2000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release
);

  // Last count value before an accepted level change.
  localparam logic [15:0] CNT_TOP = 16'(DEB_MAX - 1);

  // Reject configurations outside the supported range at elaboration.
  if (DEB_MAX < 2 || DEB_MAX > 65535 || REP_DLY < 1 || REP_PER < 1) begin : g_bad_param
    $error("btn_debounce: illegal parameter value");
  end

  logic [N-1:0] r_s1;
  logic [N-1:0] r_s2;
  logic [15:0]  r_cnt [N];
  logic [N-1:0] r_level;
  logic [N-1:0] r_press;
  logic [N-1:0] r_release;

  logic [15:0]  w_cnt_nxt [N];
  logic [N-1:0] w_level_nxt;
  logic [N-1:0] w_press_nxt;
  logic [N-1:0] w_release_nxt;
  logic [N-1:0] w_rep;

  // Two-flop synchronizer bringing the asynchronous pads into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= {N{1'b0}};
      r_s2 <= {N{1'b0}};
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
    end
  end

  // Stability counter: count mismatch cycles, accept the new level after DEB_MAX of them.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = {N{1'b0}};
    w_release_nxt = {N{1'b0}};
    for (int c = 0; c < N; c++) begin
      if (r_s2[c] == r_level[c]) begin
        w_cnt_nxt[c] = 16'd0;
      end else if (r_cnt[c] == CNT_TOP) begin
        // Saturation point doubles as the accept point, so the counter never wraps.
        w_cnt_nxt[c]     = 16'd0;
        w_level_nxt[c]   = ~r_level[c];
        w_press_nxt[c]   = ~r_level[c];
        w_release_nxt[c] = r_level[c];
      end else begin
        w_cnt_nxt[c] = r_cnt[c] + 16'd1;
      end
    end
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam logic [31:0] REP_DLY_M1 = 32'(REP_DLY - 1);
  localparam logic [31:0] REP_PER_M1 = 32'(REP_PER - 1);

  logic [31:0]  r_tmr [N];
  logic [N-1:0] r_first;
  logic [31:0]  w_tmr_nxt [N];
  logic [N-1:0] w_first_nxt;

  // Repeat timer: idle while released or releasing, then first delay, then period.
  always_comb begin
    w_tmr_nxt   = r_tmr;
    w_first_nxt = r_first;
    w_rep       = {N{1'b0}};
    for (int c = 0; c < N; c++) begin
      if (!r_level[c] || !w_level_nxt[c]) begin
        // Covers the press edge (timer starts from 0) and the release edge (no repeat).
        w_tmr_nxt[c]   = 32'd0;
        w_first_nxt[c] = 1'b1;
      end else if (r_tmr[c] == (r_first[c] ? REP_DLY_M1 : REP_PER_M1)) begin
        w_tmr_nxt[c]   = 32'd0;
        w_first_nxt[c] = 1'b0;
        w_rep[c]       = 1'b1;
      end else begin
        w_tmr_nxt[c] = r_tmr[c] + 32'd1;
      end
    end
  end

  // Repeat timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        r_tmr[c] <= 32'd0;
      end
      r_first <= {N{1'b1}};
    end else begin
      r_tmr   <= w_tmr_nxt;
      r_first <= w_first_nxt;
    end
  end
`else
  assign w_rep = {N{1'b0}};
`endif

  // Registered level, counters and one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        r_cnt[c] <= 16'd0;
      end
      r_level   <= {N{1'b0}};
      r_press   <= {N{1'b0}};
      r_release <= {N{1'b0}};
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt | w_rep;
      r_release <= w_release_nxt;
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with DEB_MAX=4, REP_DLY=10, REP_PER=5.
module tb_btn_debounce;

  localparam int N       = 4;
  localparam int DEB_MAX = 4;
  localparam int REP_DLY = 10;
  localparam int REP_PER = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int n_cmp = 0;
  int n_err = 0;

  btn_debounce #(
    .N(N), .DEB_MAX(DEB_MAX), .REP_DLY(REP_DLY), .REP_PER(REP_PER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: a channel flips once the synchronized input (btn_in
  // delayed by two edges) has disagreed with the level on each of the last
  // DEB_MAX edges; repeats are arithmetic on the edge distance from the press.
  logic [N-1:0]       m_level, m_press, m_release;
  logic [N-1:0]       m_d1, m_d2;
  logic [DEB_MAX-1:0] m_win [N];
  int                 m_edge;
  int                 m_press_edge [N];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_level = '0; m_press = '0; m_release = '0;
        m_d1 = '0; m_d2 = '0; m_edge = 0;
        for (int c = 0; c < N; c++) begin
          m_win[c] = '0;
          m_press_edge[c] = 0;
        end
      end else begin
        m_edge = m_edge + 1;
        for (int c = 0; c < N; c++) begin
          m_win[c] = {m_win[c][DEB_MAX-2:0], m_d2[c]};
          m_press[c] = 1'b0;
          m_release[c] = 1'b0;
          if (m_win[c] == {DEB_MAX{~m_level[c]}}) begin
            m_level[c] = ~m_level[c];
            if (m_level[c]) begin
              m_press[c] = 1'b1;
              m_press_edge[c] = m_edge;
            end else begin
              m_release[c] = 1'b1;
            end
          end
`ifdef BTN_DEBOUNCE_REPEAT_EN
          else if (m_level[c] && (m_edge - m_press_edge[c]) >= REP_DLY &&
                   ((m_edge - m_press_edge[c] - REP_DLY) % REP_PER) == 0) begin
            m_press[c] = 1'b1;
          end
`endif
        end
        m_d2 = m_d1;
        m_d1 = btn_in;
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_level",   btn_level,   m_level);
      chk("model_press",   btn_press,   m_press);
      chk("model_release", btn_release, m_release);
      if ((btn_press & btn_release) != '0) begin
        chk("press_and_release_overlap", btn_press & btn_release, 4'b0000);
      end
    end
  end

  logic [N-1:0] rep_exp;

  initial begin
    // Reset state
    step(3);
    chk("reset_level", btn_level, 4'b0000);
    chk("reset_press", btn_press, 4'b0000);
    chk("reset_release", btn_release, 4'b0000);
    rst_n = 1'b1;
    step(3);

    // Clean press on channel 0: level and pulse on edge 5
    btn_in = 4'b0001;
    step(5);
    chk("clean_edge4_level", btn_level, 4'b0000);
    chk("clean_edge4_press", btn_press, 4'b0000);
    step(1);
    chk("clean_edge5_level", btn_level, 4'b0001);
    chk("clean_edge5_press", btn_press, 4'b0001);
    chk("clean_edge5_release", btn_release, 4'b0000);
    step(1);
    chk("clean_edge6_press", btn_press, 4'b0000);
    btn_in = 4'b0000;
    step(8);
    chk("clean_released_level", btn_level, 4'b0000);

    // Bounce on channel 1 with 3-cycle runs, then held high
    btn_in = 4'b0010; step(3);
    btn_in = 4'b0000; step(3);
    btn_in = 4'b0010; step(3);
    btn_in = 4'b0000; step(3);
    chk("bounce_no_level", btn_level, 4'b0000);
    btn_in = 4'b0010;
    step(5);
    chk("bounce_edge4_press", btn_press, 4'b0000);
    step(1);
    chk("bounce_edge5_press", btn_press, 4'b0010);
    chk("bounce_edge5_level", btn_level, 4'b0010);

    // Release path on channel 2
    btn_in = 4'b0110;
    step(8);
    chk("release_setup_level", btn_level, 4'b0110);
    btn_in = 4'b0010;
    step(5);
    chk("release_edge4_release", btn_release, 4'b0000);
    step(1);
    chk("release_edge5_release", btn_release, 4'b0100);
    chk("release_edge5_level", btn_level, 4'b0010);
    chk("release_edge5_press_ch2", btn_press & 4'b0100, 4'b0000);

    // Simultaneous press on all channels
    btn_in = 4'b0000;
    step(8);
    btn_in = 4'b1111;
    step(5);
    chk("simul_edge4_press", btn_press, 4'b0000);
    step(1);
    chk("simul_edge5_press", btn_press, 4'b1111);
    chk("simul_edge5_level", btn_level, 4'b1111);
    step(1);
    chk("simul_edge6_press", btn_press, 4'b0000);

    // Auto-repeat at press+10 and press+15 only when the feature is built in
`ifdef BTN_DEBOUNCE_REPEAT_EN
    rep_exp = 4'b1111;
`else
    rep_exp = 4'b0000;
`endif
    step(9);
    chk("repeat_edge15_press", btn_press, rep_exp);
    step(4);
    chk("repeat_edge19_press", btn_press, 4'b0000);
    step(1);
    chk("repeat_edge20_press", btn_press, rep_exp);
    step(1);
    chk("repeat_edge21_press", btn_press, 4'b0000);
    btn_in = 4'b0000;
    step(8);
    chk("repeat_released_level", btn_level, 4'b0000);

    // Reset mid-count with buttons held through reset
    btn_in = 4'b0011;
    step(8);
    chk("rst_setup_level", btn_level, 4'b0011);
    btn_in = 4'b0111;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_level", btn_level, 4'b0000);
    chk("rst_async_press", btn_press, 4'b0000);
    chk("rst_async_release", btn_release, 4'b0000);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("rst_edge4_level", btn_level, 4'b0000);
    step(1);
    chk("rst_edge5_level", btn_level, 4'b0111);
    chk("rst_edge5_press", btn_press, 4'b0111);
    step(1);

    // Release everything and idle
    btn_in = 4'b0000;
    step(10);
    chk("final_level", btn_level, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
